// File: rtl/instr_sequencer_pkg.sv
// Shared types for the instruction sequencer: FSM state encoding, status nibble
// bit positions and the hex-to-seven-segment mapping.
package instr_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2,
        ST_WAIT  = 2'd3
    } state_e;

    localparam int STAT_RUN  = 0;
    localparam int STAT_BUSY = 1;
    localparam int STAT_ERR  = 2;
    localparam int STAT_DONE = 3;

    // Active-high segments, bit 0 = a ... bit 6 = g
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/instr_sequencer_decod7seg.sv
// Single-digit hex to seven-segment decoder (active-high, a in bit 0).
module instr_sequencer_decod7seg
    import instr_sequencer_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = hex_to_seg(nibble_i);

endmodule

// File: rtl/instr_sequencer.sv
// Program-RAM instruction sequencer: issues entries over valid/ready in single-step
// or auto-run mode, captures results and shows them on seven-segment digits.
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int INSTR_W  = 22,
    parameter int DEPTH    = 21,
    parameter int ADDR_W   = 5,
    parameter int RESULT_W = 16,
    parameter int DIGITS   = 4,
    parameter int TIMEOUT  = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  step_i,
    input  logic                  run_i,
    input  logic                  disp_sel_i,
    input  logic                  prog_we_i,
    input  logic [ADDR_W-1:0]     prog_addr_i,
    input  logic [INSTR_W-1:0]    prog_data_i,
    output logic [INSTR_W-1:0]    instr_o,
    output logic                  instr_valid_o,
    input  logic                  instr_ready_i,
    input  logic [RESULT_W-1:0]   result_i,
    input  logic                  result_valid_i,
    output logic [ADDR_W-1:0]     pc_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [7*DIGITS-1:0]   seg_o
);

    localparam int CNT_W = $clog2(TIMEOUT);

    logic [INSTR_W-1:0]  prog_mem_q [DEPTH];

    state_e              state_q,  state_d;
    logic [ADDR_W-1:0]   pc_q,     pc_d;
    logic [INSTR_W-1:0]  instr_q,  instr_d;
    logic                valid_q,  valid_d;
    logic                busy_q,   busy_d;
    logic                done_q,   done_d;
    logic                err_q,    err_d;
    logic [RESULT_W-1:0] result_q, result_d;
    logic [CNT_W-1:0]    tmo_q,    tmo_d;
    logic                step_q;

    logic                req_s;
    logic                start_s;
    logic                last_s;
    logic                auto_s;
    logic [3:0]          status_s;
    logic [4*DIGITS-1:0] disp_val_s;

    // Next-state and next-output computation for the sequencer FSM
    always_comb begin
        req_s    = step_i & ~step_q;
        auto_s   = run_i & ~err_q;
        // A timeout blocks auto-run; an explicit step still goes through in single-step
        start_s  = run_i ? (~err_q & (req_s | ~done_q)) : req_s;
        last_s   = (pc_q == ADDR_W'(DEPTH - 1));

        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        valid_d  = valid_q;
        err_d    = err_q;
        result_d = result_q;
        tmo_d    = tmo_q;

        if (req_s || !run_i) begin
            done_d = 1'b0;
        end else begin
            done_d = done_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_s) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FETCH: begin
                instr_d = prog_mem_q[pc_q];
                valid_d = 1'b1;
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (valid_q && instr_ready_i) begin
                    valid_d = 1'b0;
                    tmo_d   = '0;
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                // Result is checked before expiry so a strobe on the last cycle still counts
                if (result_valid_i) begin
                    result_d = result_i;
                    pc_d     = last_s ? '0 : pc_q + ADDR_W'(1);
                    if (auto_s && last_s) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else if (auto_s) begin
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (tmo_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d   = tmo_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State, datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            pc_q     <= '0;
            instr_q  <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
            tmo_q    <= '0;
            step_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            result_q <= result_d;
            tmo_q    <= tmo_d;
            step_q   <= step_i;
        end
    end

    // Program RAM write port, open only while idle; contents survive reset
    always_ff @(posedge clk) begin
        if (prog_we_i && (state_q == ST_IDLE) && (int'(prog_addr_i) < DEPTH)) begin
            prog_mem_q[prog_addr_i] <= prog_data_i;
        end
    end

    // Display source selection: result, or {pc, status} with pc zero-padded upward
    always_comb begin
        status_s            = 4'b0000;
        status_s[STAT_RUN]  = run_i;
        status_s[STAT_BUSY] = busy_q;
        status_s[STAT_ERR]  = err_q;
        status_s[STAT_DONE] = done_q;
        if (disp_sel_i) begin
            disp_val_s = {{(4*DIGITS-4-ADDR_W){1'b0}}, pc_q, status_s};
        end else begin
            disp_val_s = result_q;
        end
    end

    for (genvar d = 0; d < DIGITS; d++) begin : g_digit
        instr_sequencer_decod7seg u_dec (
            .nibble_i (disp_val_s[4*d +: 4]),
            .seg_o    (seg_o[7*d +: 7])
        );
    end

    assign instr_o       = instr_q;
    assign instr_valid_o = valid_q;
    assign pc_o          = pc_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign err_o         = err_q;

endmodule
